// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit multiplexed 7-segment driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; the dp bit is added by the top.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Indexed by the nibble value 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    // Active-low enable with only the selected digit pulled low.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/display_seg7_decode.sv
// Combinational hex-to-7-segment decoder: 4-bit nibble in, active-low {g..a} out.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/display.sv
// Four-digit multiplexed common-anode 7-segment driver showing a 16-bit value in hex.
// Define DISPLAY_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module display
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] display_num,
    output logic [3:0]  anode,
    output logic [7:0]  segment
);

    localparam int TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);

    logic [TICK_W-1:0] tick;
    digit_idx_t        idx;
    logic [3:0]        nibble;
    logic [6:0]        seg_code;
    logic              blank;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
            idx  <= idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign nibble = display_num[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg_code)
    );

`ifdef DISPLAY_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    logic [15:0] upper;
    assign upper = display_num >> {idx, 2'b00};
    assign blank = (idx != '0) && (upper == '0);
`else
    assign blank = 1'b0;
`endif

    // Registered pins: one clock of latency from idx or display_num to the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode   <= ANODE_OFF;
            segment <= SEG_OFF;
        end else begin
            anode   <= anode_for(idx);
            segment <= blank ? SEG_OFF : {1'b1, seg_code};
        end
    end

endmodule

// File: tb/tb_display.sv
// Directed self-checking bench for display, run with DIGIT_CYCLES=4.
// Expected segment codes are the hand-written active-low pin values for each hex digit.
module tb_display;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] display_num;
    logic [3:0]  anode;
    logic [7:0]  segment;

    int checks = 0;
    int passed = 0;

    display #(.DIGIT_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .display_num (display_num),
        .anode       (anode),
        .segment     (segment)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hex_pins(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] num, input int d);
        logic [3:0] nib;
        nib = num[4*d +: 4];
`ifdef DISPLAY_BLANK_EN
        if (d != 0 && (num >> (4*d)) == 16'h0)
            return 8'hFF;
`endif
        return hex_pins(nib);
    endfunction

    function automatic logic [7:0] exp_anode(input int d);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        return {4'h0, a};
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        display_num = 16'h1234;

        // Reset: all dark, then digit 0 on the first edge after release.
        repeat (3) step();
        check("rst_anode", {4'h0, anode}, 8'h0F);
        check("rst_seg", segment, 8'hFF);
        rst = 1'b0;

        // Full scan of 0x1234: four clocks per digit, digits 0..3.
        for (int k = 0; k < 4 * DC; k++) begin
            step();
            check($sformatf("scan_anode_%0d", k), {4'h0, anode}, exp_anode(k / DC));
            check($sformatf("scan_seg_%0d", k), segment, exp_seg(16'h1234, k / DC));
        end

        // Nibble sweep on digit 0, four values per reset so digit 0 stays lit.
        for (int g = 0; g < 4; g++) begin
            pulse_reset();
            for (int j = 0; j < 4; j++) begin
                logic [3:0] n;
                n = 4'(g * 4 + j);
                display_num = {12'hABC, n};
                step();
                check($sformatf("sweep_anode_%h", n), {4'h0, anode}, 8'h0E);
                check($sformatf("sweep_seg_%h", n), segment, hex_pins(n));
                check($sformatf("sweep_dp_%h", n), {7'h0, segment[7]}, 8'h01);
            end
        end

        // Reset while digit 2 is lit restarts the scan from digit 0.
        display_num = 16'h1234;
        pulse_reset();
        repeat (2 * DC + 1) step();
        check("mid_anode_d2", {4'h0, anode}, 8'h0B);
        rst = 1'b1;
        step();
        check("mid_rst_anode", {4'h0, anode}, 8'h0F);
        check("mid_rst_seg", segment, 8'hFF);
        rst = 1'b0;
        for (int k = 0; k < DC; k++) begin
            step();
            check($sformatf("restart_anode_%0d", k), {4'h0, anode}, 8'h0E);
            check($sformatf("restart_seg_%0d", k), segment, 8'h99);
        end
        step();
        check("restart_next_anode", {4'h0, anode}, 8'h0D);

        // Mid-scan value change shows on the very next edge.
        display_num = 16'h0000;
        pulse_reset();
        repeat (DC + 1) step();
        check("chg_anode_before", {4'h0, anode}, 8'h0D);
`ifdef DISPLAY_BLANK_EN
        check("chg_seg_before", segment, 8'hFF);
`else
        check("chg_seg_before", segment, 8'hC0);
`endif
        display_num = 16'h00FF;
        step();
        check("chg_anode_after", {4'h0, anode}, 8'h0D);
        check("chg_seg_after", segment, 8'h8E);

        // 0x0005: digit 0 shows "5"; upper digits are blank or "0" depending on build.
        display_num = 16'h0005;
        pulse_reset();
        for (int k = 0; k < 4 * DC; k++) begin
            logic [7:0] want;
            step();
            if (k / DC == 0)
                want = 8'h92;
            else
`ifdef DISPLAY_BLANK_EN
                want = 8'hFF;
`else
                want = 8'hC0;
`endif
            check($sformatf("lz_anode_%0d", k), {4'h0, anode}, exp_anode(k / DC));
            check($sformatf("lz_seg_%0d", k), segment, want);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
